// File: rtl/jk_cmd_if.sv
// Command/feedback bundle between a sequencer driver and jk_cmd_sequencer.
interface jk_cmd_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;
  logic             q_fb;
  logic             j;
  logic             k;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] done_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             busy;

  modport master (
    output cmd_valid, cmd_op, q_fb,
    input  cmd_ready, j, k, done, err, done_cnt, err_cnt, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, q_fb,
    output cmd_ready, j, k, done, err, done_cnt, err_cnt, busy
  );
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Queues JK commands, drives j/k for one cycle per command and checks the
// flip-flop's q feedback one cycle later, counting completions and mismatches.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  jk_cmd_if.slave   cmd_bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

  state_t           state_q, state_d;
  logic [1:0]       fifo_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [1:0]       op_q, op_d;
  logic             j_q, j_d, k_q, k_d;
  logic             exp_q, exp_d;
  logic [CNT_W-1:0] done_cnt_q, err_cnt_q;

  logic full, empty, push, pop, done, err;

  // Occupancy counter keeps full/empty exact regardless of pointer wrap.
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = cmd_bus.cmd_valid && !full;
  assign done  = (state_q == CHECK);
  assign err   = done && (cmd_bus.q_fb != exp_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    exp_d   = exp_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          op_d    = fifo_q[rd_ptr_q];
          j_d     = op_d[1];
          k_d     = op_d[0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Expected q after the flop clocks with the j/k driven this cycle.
        case (op_q)
          2'b00:   exp_d = cmd_bus.q_fb;
          2'b01:   exp_d = 1'b0;
          2'b10:   exp_d = 1'b1;
          default: exp_d = ~cmd_bus.q_fb;
        endcase
        state_d = CHECK;
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_q       <= 2'b00;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      exp_q      <= 1'b0;
      done_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      j_q     <= j_d;
      k_q     <= k_d;
      exp_q   <= exp_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (done && done_cnt_q != '1) done_cnt_q <= done_cnt_q + CNT_W'(1);
      if (err  && err_cnt_q  != '1) err_cnt_q  <= err_cnt_q  + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= cmd_bus.cmd_op;
  end

  assign cmd_bus.cmd_ready = !full;
  assign cmd_bus.j         = j_q;
  assign cmd_bus.k         = k_q;
  assign cmd_bus.done      = done;
  assign cmd_bus.err       = err;
  assign cmd_bus.done_cnt  = done_cnt_q;
  assign cmd_bus.err_cnt   = err_cnt_q;
  assign cmd_bus.busy      = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Random command traffic against a schedule-based model: each accepted command
// gets a pop edge max(accept+1, prev_pop+3); outputs are derived from that schedule.
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = 1024;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jk_cmd_if #(.CNT_W(CNT_W)) bus ();
  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_bus(bus)
  );

  always #5 clk = ~clk;

  // Downstream JK flip-flop; stuck forces the feedback low.
  logic q_ff  = 1'b0;
  logic stuck = 1'b0;
  assign bus.q_fb = stuck ? 1'b0 : q_ff;
  always @(posedge clk)
    case ({bus.j, bus.k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  int A [MAXC];
  int P [MAXC];
  logic [1:0] OPS [MAXC];
  int n_cmd = 0, last_p = -100, done_m = 0, err_m = 0;
  logic qm = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic apply(input logic [1:0] op, input logic q);
    case (op)
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  function automatic int occ(input int c);
    int o = 0;
    for (int i = 0; i < n_cmd; i++) if (A[i] <= c && P[i] > c) o++;
    return o;
  endfunction

  function automatic int find_pop(input int c);
    for (int i = 0; i < n_cmd; i++) if (P[i] == c) return i;
    return -1;
  endfunction

  // Compare all outputs for the current cycle, then retire a checked command.
  task automatic check_cycle();
    int c, iss, ck, o;
    logic b, qa, a, err_e;
    c = cyc; iss = find_pop(c); ck = find_pop(c - 1); o = occ(c);
    err_e = 1'b0; qa = qm;
    chk("cmd_ready", bus.cmd_ready, o < DEPTH);
    chk("busy", bus.busy, (o > 0) || (iss >= 0) || (ck >= 0));
    chk("j", bus.j, (iss >= 0) ? OPS[iss][1] : 1'b0);
    chk("k", bus.k, (iss >= 0) ? OPS[iss][0] : 1'b0);
    chk("done", bus.done, ck >= 0);
    if (ck >= 0) begin
      b  = stuck ? 1'b0 : qm;
      qa = apply(OPS[ck], qm);
      a  = stuck ? 1'b0 : qa;
      err_e = (apply(OPS[ck], b) != a);
      chk("q_fb", bus.q_fb, a);
    end
    chk("err", bus.err, err_e);
    chk("done_cnt", bus.done_cnt, done_m);
    chk("err_cnt", bus.err_cnt, err_m);
    if (ck >= 0) begin
      qm = qa;
      if (done_m < SAT) done_m++;
      if (err_e && err_m < SAT) err_m++;
    end
  endtask

  // Called at a negedge: check, drive, advance one cycle to the next negedge.
  task automatic step(input bit v, input logic [1:0] op);
    check_cycle();
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    if (v && occ(cyc) < DEPTH && n_cmd < MAXC) begin
      A[n_cmd]   = cyc + 1;
      P[n_cmd]   = (cyc + 2 > last_p + 3) ? cyc + 2 : last_p + 3;
      OPS[n_cmd] = op;
      last_p     = P[n_cmd];
      n_cmd++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_ready"}, bus.cmd_ready, 1'b1);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_jk"}, {bus.j, bus.k}, 2'b00);
    chk({tag, "_done_err"}, {bus.done, bus.err}, 2'b00);
    chk({tag, "_done_cnt"}, bus.done_cnt, 0);
    chk({tag, "_err_cnt"}, bus.err_cnt, 0);
  endtask

  // Entered and left at a negedge; rst rises mid-cycle to exercise the async path.
  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1 rst_vals("rst_async");
    @(posedge clk);
    @(negedge clk);
    rst_vals("rst_held");
    rst = 1'b0;
    n_cmd = 0; last_p = -100; done_m = 0; err_m = 0;
  endtask

  task automatic drain();
    int g = 0;
    while (n_cmd > 0 && last_p + 1 >= cyc && g < 100) begin
      step(1'b0, 2'b00);
      g++;
    end
    if (g >= 100) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int g;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    @(negedge clk);
    do_reset();

    // Single set from q=0, then four back-to-back toggles from q=1.
    step(1'b1, 2'b10);
    drain();
    repeat (4) step(1'b1, 2'b11);
    drain();

    // Continuous offers overfill the FIFO.
    repeat (20) step(1'b1, 2'($urandom_range(0, 3)));
    drain();

    // Reset while a clear is in ISSUE aborts it.
    do_reset();
    step(1'b1, 2'b01);
    while (cyc < P[0]) step(1'b0, 2'b00);
    check_cycle();
    do_reset();

    repeat (600) step($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)));
    drain();

    stuck = 1'b1;
    repeat (300) step($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)));
    drain();
    stuck = 1'b0;

    // 300 sets against a stuck-low flop saturate both counters.
    do_reset();
    stuck = 1'b1;
    g = 0;
    while (n_cmd < 300 && g < 2000) begin
      step(1'b1, 2'b10);
      g++;
    end
    drain();
    chk("sat_done_cnt", bus.done_cnt, SAT);
    chk("sat_err_cnt", bus.err_cnt, SAT);
    check_cycle();
    stuck = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
